// File: rtl/moore_d_pkg.sv
// Shared constants, types and elaboration-time helpers for the moore_d detector.
package moore_d_pkg;

    localparam int unsigned MAX_LEN   = 16;
    localparam int unsigned MAX_SW    = 5;
    localparam int unsigned TBL_IDX_W = MAX_SW + 1;
    localparam int unsigned TBL_DEPTH = 2 ** TBL_IDX_W;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    typedef logic [MAX_SW-1:0] st_t;
    // Indexed by {state, x}; unreachable state codes map to S0.
    typedef st_t [TBL_DEPTH-1:0] ns_tbl_t;

    // Ceiling log2 with a floor of one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Pattern bit i in arrival order (i = 0 is the first bit received, the MSB).
    function automatic logic pattern_bit(input logic [MAX_LEN-1:0] pat,
                                         input int unsigned len,
                                         input int unsigned i);
        logic [MAX_LEN-1:0] s;
        s = pat >> (len - 1 - i);
        return s[0];
    endfunction

    // Next state = longest pattern prefix that is a suffix of (prefix_k, b).
    function automatic ns_tbl_t next_state_table(input logic [MAX_LEN-1:0] pat,
                                                 input int unsigned len);
        ns_tbl_t tbl;
        tbl = '0;
        for (int unsigned k = 0; k <= len; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                int unsigned best;
                int unsigned lim;
                best = 0;
                lim  = (k + 1 < len) ? k + 1 : len;
                for (int unsigned j = 1; j <= lim; j++) begin
                    logic ok;
                    ok = 1'b1;
                    for (int unsigned m = 0; m < j; m++) begin
                        int unsigned c;
                        logic        cb;
                        c  = k + 1 - j + m;
                        cb = (c == k) ? 1'(b) : pattern_bit(pat, len, c);
                        if (cb != pattern_bit(pat, len, m)) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = j;
                    end
                end
                tbl[TBL_IDX_W'(2 * k + b)] = MAX_SW'(best);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/moore_d_dff_ar.sv
// Parameterised-width D register with asynchronous active-low clear.
module dff_ar #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear immediately on reset, otherwise capture d on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/moore_d.sv
// Moore serial sequence detector: tracks the longest matched pattern prefix
// (overlap allowed) and flags a full match on z for one cycle per match.
module moore_d
    import moore_d_pkg::*;
#(
    parameter int unsigned     LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = LEN'(DEFAULT_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    localparam int unsigned SW     = clog2(LEN + 1);
    localparam ns_tbl_t     NS_TBL = next_state_table(MAX_LEN'(PATTERN), LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;
    logic          z_nxt;

    // Next-state lookup from the elaborated table; z is preloaded from it.
    always_comb begin
        state_nxt = '0;
        z_nxt     = 1'b0;
        state_nxt = SW'(NS_TBL[TBL_IDX_W'({state, x})]);
        z_nxt     = (state_nxt == SW'(LEN));
    end

    dff_ar #(.W(SW)) u_state (
        .clk   (clk),
        .rst_n (reset),
        .d     (state_nxt),
        .q     (state)
    );

    dff_ar #(.W(1)) u_z (
        .clk   (clk),
        .rst_n (reset),
        .d     (z_nxt),
        .q     (z)
    );

endmodule

// File: tb/tb_moore_d.sv
// Directed bench for moore_d: default pattern, a self-overlapping LEN=3
// pattern and the LEN=1 corner, all sharing clock, reset and x.
module tb_moore_d;

    logic clk;
    logic reset;
    logic x;
    logic z4;
    logic z3;
    logic z1;

    int total;
    int bad;

    moore_d dut4 (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z4)
    );

    moore_d #(.LEN(3), .PATTERN(3'b111)) dut3 (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z3)
    );

    moore_d #(.LEN(1), .PATTERN(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply n bits (MSB first), one per clock, and check the selected z after each edge.
    task automatic run(input string tag, input int n, input logic [15:0] bits,
                       input logic [15:0] ez, input int which);
        logic [15:0] t;
        logic [15:0] e;
        logic        obs;
        for (int i = n - 1; i >= 0; i--) begin
            t = bits >> i;
            x = t[0];
            @(posedge clk);
            #1;
            e   = ez >> i;
            obs = (which == 4) ? z4 : ((which == 3) ? z3 : z1);
            chk($sformatf("%s[%0d]", tag, n - 1 - i), {4'b0, obs}, {4'b0, e[0]});
        end
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        x     = 1'b0;

        // Asynchronous reset: outputs cleared before any clock edge.
        #1;
        chk("rst_z4_noclk", {4'b0, z4}, 5'd0);
        chk("rst_z3_noclk", {4'b0, z3}, 5'd0);
        chk("rst_z1_noclk", {4'b0, z1}, 5'd0);
        chk("rst_st_noclk", 5'(dut4.state), 5'd0);

        // Reset held with x toggling.
        for (int c = 0; c < 3; c++) begin
            x = ~x;
            @(posedge clk);
            #1;
            chk($sformatf("rst_hold_z4[%0d]", c), {4'b0, z4}, 5'd0);
            chk($sformatf("rst_hold_z1[%0d]", c), {4'b0, z1}, 5'd0);
            chk($sformatf("rst_hold_st[%0d]", c), 5'(dut4.state), 5'd0);
        end
        reset = 1'b1;

        // Default pattern 1011 inside 0101101.
        run("dflt", 7, 16'b0101101, 16'b0000100, 4);
        chk("dflt_final_st", 5'(dut4.state), 5'd3);
        pulse_reset();

        // Overlapping matches, then async reset while z is high.
        run("ovl", 7, 16'b1011011, 16'b0001001, 4);
        reset = 1'b0;
        #2;
        chk("async_drop_z4", {4'b0, z4}, 5'd0);
        chk("async_drop_st", 5'(dut4.state), 5'd0);
        reset = 1'b1;

        // Near misses: S2 on 0 -> S0, S3 on 0 -> S2.
        run("near_a", 3, 16'b100, 16'b000, 4);
        chk("near_s2_to_s0", 5'(dut4.state), 5'd0);
        run("near_b", 4, 16'b1010, 16'b0000, 4);
        chk("near_s3_to_s2", 5'(dut4.state), 5'd2);
        run("near_c", 2, 16'b11, 16'b01, 4);
        pulse_reset();

        // Reset mid-match discards the partial prefix.
        run("mid_a", 3, 16'b101, 16'b000, 4);
        chk("mid_pre_st", 5'(dut4.state), 5'd3);
        pulse_reset();
        chk("mid_post_st", 5'(dut4.state), 5'd0);
        run("mid_b", 1, 16'b1, 16'b0, 4);
        pulse_reset();
        run("mid_c", 3, 16'b011, 16'b000, 4);
        pulse_reset();
        run("mid_d", 4, 16'b1011, 16'b0001, 4);
        pulse_reset();

        // LEN=3 all-ones: z held from bit 3 onward.
        run("len3", 6, 16'b111111, 16'b001111, 3);
        chk("len3_st", 5'(dut3.state), 5'd3);
        pulse_reset();

        // LEN=1: z follows x delayed by one edge.
        run("len1", 6, 16'b110110, 16'b110110, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
